// File: rtl/alu_seq_n_if.sv
// ============================================================================
// Module      : alu_seq_n_if
// Description : Request/response bundle between the operand register file and
//               the sequential ALU (start/busy/done handshake plus result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_n_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [4:0]       f;
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             dz;

    modport master (output start, f, v, a, b, input busy, done, y, dz);
    modport slave  (input start, f, v, a, b, output busy, done, y, dz);
endinterface

`default_nettype wire

// File: rtl/alu_seq_n.sv
// ============================================================================
// Module      : alu_seq_n
// Description : Width-parametrised multi-cycle ALU: single-cycle logic/arith
//               ops, iterative shift-add multiply and restoring divide.
//               Divider compiled in only when ALU_SEQ_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_n #(
    parameter int WIDTH = 4
) (
    input  wire logic    CLK,
    input  wire logic    CLR,
    alu_seq_n_if.slave   bus
);
    localparam int         c_CW     = $clog2(WIDTH + 1);
    localparam logic [4:0] c_OP_SHL = 5'b00000;
    localparam logic [4:0] c_OP_ADD = 5'b00010;
    localparam logic [4:0] c_OP_SUB = 5'b00011;
    localparam logic [4:0] c_OP_MUL = 5'b00100;
    localparam logic [4:0] c_OP_DIV = 5'b00110;
    localparam logic [4:0] c_OP_AND = 5'b01000;
    localparam logic [4:0] c_OP_OR  = 5'b01100;
    localparam logic [4:0] c_OP_SHR = 5'b10000;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_v;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_y;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_single;
    logic               w_dz_single;
    logic               w_div_start;
    logic               w_last;
    logic [WIDTH:0]     w_mul_upper;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_last = (r_cnt == c_CW'(WIDTH - 1));

    // Multiplier sits in the low half of r_acc and is consumed LSB first.
    assign w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_acc_next  = {w_mul_upper, r_acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Partial remainder is widened by one bit for the trial subtraction.
    assign w_shift     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_b};
    assign w_ge        = ~w_trial[WIDTH];
    assign w_rem_next  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_ge};
    assign w_div_start = (bus.f == c_OP_DIV) && (bus.b != '0);
    assign w_dz_single = (bus.f == c_OP_DIV);
`else
    assign w_div_start = 1'b0;
    assign w_dz_single = 1'b0;
`endif

    always_comb begin
        w_single = '0;
        case (bus.f)
            c_OP_ADD: w_single = bus.v ? WIDTH'(w_sum[WIDTH]) : w_sum[WIDTH-1:0];
            c_OP_SUB: w_single = bus.v ? {WIDTH{w_diff[WIDTH]}} : w_diff[WIDTH-1:0];
            c_OP_AND: w_single = bus.a & bus.b;
            c_OP_OR:  w_single = bus.a | bus.b;
            c_OP_SHL: w_single = {bus.a[WIDTH-2:0], 1'b0};
            c_OP_SHR: w_single = {1'b0, bus.a[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
            // Only reached with b == 0; nonzero divisors take the iterative path.
            c_OP_DIV: w_single = bus.v ? bus.a : {WIDTH{1'b1}};
`endif
            default:  w_single = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_v     <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_v    <= bus.v;
                        r_b    <= bus.b;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.f == c_OP_MUL) begin
                            r_acc   <= {{WIDTH{1'b0}}, bus.a};
                            r_state <= S_MUL;
                        end else if (w_div_start) begin
`ifdef ALU_SEQ_DIV_EN
                            r_quo   <= bus.a;
                            r_rem   <= '0;
`endif
                            r_state <= S_DIV;
                        end else begin
                            r_y     <= w_single;
                            r_dz    <= w_dz_single;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_y     <= r_v ? w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[WIDTH-1:0];
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_y     <= r_v ? w_rem_next : w_quo_next;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.y    = r_y;
    assign bus.dz   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_n.sv
// ============================================================================
// Module      : tb_alu_seq_n
// Description : Self-checking bench for alu_seq_n at WIDTH=4 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_n;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    alu_seq_n_if #(.WIDTH(W)) bus4 ();
    alu_seq_n_if #(.WIDTH(8)) bus8 ();

    alu_seq_n #(.WIDTH(W)) dut4 (.CLK(CLK), .CLR(CLR), .bus(bus4));
    alu_seq_n #(.WIDTH(8)) dut8 (.CLK(CLK), .CLR(CLR), .bus(bus8));

    int n_vec = 0;
    int n_err = 0;
    bit inject = 1'b0;

    typedef struct {
        logic [4:0]   f;
        logic         v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: result straight from the opcode table with integer arithmetic.
    function automatic void model(input int w, input logic [4:0] f, input logic v,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned y, output logic dz, output int lat);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned t;
        y = 0; dz = 1'b0; lat = 1;
        case (f)
            5'b00010: begin t = a + b; y = v ? (t >> w) : (t & mask); end
            5'b00011: y = v ? ((a < b) ? mask : 0) : ((a - b) & mask);
            5'b01000: y = a & b;
            5'b01100: y = a | b;
            5'b00000: y = (a << 1) & mask;
            5'b10000: y = a >> 1;
            5'b00100: begin t = a * b; lat = w + 1; y = v ? (t >> w) : (t & mask); end
`ifdef ALU_SEQ_DIV_EN
            5'b00110: begin
                if (b == 0) begin dz = 1'b1; y = v ? a : mask; end
                else begin lat = w + 1; y = v ? (a % b) : (a / b); end
            end
`endif
            default: y = 0;
        endcase
    endfunction

    task automatic run4(input logic [4:0] f, input logic v, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] y, output logic dz,
                        output int lat);
        int guard = 0;
        while (bus4.busy && guard < 50) begin @(posedge CLK); #1; guard++; end
        if (guard >= 50) begin n_vec++; n_err++; $display("FAIL idle_wait4: busy stuck at 1"); end
        bus4.start = 1'b1; bus4.f = f; bus4.v = v; bus4.a = a; bus4.b = b;
        @(posedge CLK); #1;
        bus4.start = 1'b0;
        bus4.f = 5'($urandom); bus4.v = 1'($urandom); bus4.a = W'($urandom); bus4.b = W'($urandom);
        lat = 1;
        while (!bus4.done && lat < 40) begin
            if (inject) bus4.start = (lat == 2);
            @(posedge CLK); #1; lat++;
        end
        y = bus4.y; dz = bus4.dz;
        if (inject) begin bus4.start = 1'b1; bus4.f = 5'b00010; end
        @(posedge CLK); #1;
        bus4.start = 1'b0;
        chk("done_busy_after4", {bus4.done, bus4.busy}, 2'b00);
    endtask

    task automatic apply4(input string name, input logic [4:0] f, input logic v,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ey, input logic edz, input int elat);
        logic [W-1:0] y; logic dz; int lat;
        run4(f, v, a, b, y, dz, lat);
        chk({name, "_y"}, y, ey);
        chk({name, "_dz"}, dz, edz);
        chk({name, "_lat"}, lat, elat);
    endtask

    task automatic run8(input logic [4:0] f, input logic v, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] y, output logic dz,
                        output int lat);
        int guard = 0;
        while (bus8.busy && guard < 50) begin @(posedge CLK); #1; guard++; end
        if (guard >= 50) begin n_vec++; n_err++; $display("FAIL idle_wait8: busy stuck at 1"); end
        bus8.start = 1'b1; bus8.f = f; bus8.v = v; bus8.a = a; bus8.b = b;
        @(posedge CLK); #1;
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        lat = 1;
        while (!bus8.done && lat < 40) begin @(posedge CLK); #1; lat++; end
        y = bus8.y; dz = bus8.dz;
        @(posedge CLK); #1;
        chk("done_busy_after8", {bus8.done, bus8.busy}, 2'b00);
    endtask

    task automatic apply8(input string name, input logic [4:0] f, input logic v,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ey, input logic edz, input int elat);
        logic [7:0] y; logic dz; int lat;
        run8(f, v, a, b, y, dz, lat);
        chk({name, "_y"}, y, ey);
        chk({name, "_dz"}, dz, edz);
        chk({name, "_lat"}, lat, elat);
    endtask

    initial begin
        logic [4:0]      ops [8];
        logic [4:0]      f;
        logic            v;
        longint unsigned my;
        logic            mdz;
        int              mlat;
        logic [W-1:0]    ra, rb;
        logic [7:0]      ra8, rb8;
        bit              seen;

        ops = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00110, 5'b01000, 5'b01100, 5'b10000};
        bus4.start = 0; bus4.f = 0; bus4.v = 0; bus4.a = 0; bus4.b = 0;
        bus8.start = 0; bus8.f = 0; bus8.v = 0; bus8.a = 0; bus8.b = 0;
        CLR = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset4", {bus4.y, bus4.done, bus4.busy, bus4.dz}, '0);
        chk("reset8", {bus8.y, bus8.done, bus8.busy, bus8.dz}, '0);
        CLR = 1'b0;

        tbl.push_back('{5'b00010, 1'b0, 4'd14, 4'd6,  4'b0100, 1'b0, 1});
        tbl.push_back('{5'b00010, 1'b1, 4'd14, 4'd6,  4'b0001, 1'b0, 1});
        tbl.push_back('{5'b00011, 1'b0, 4'd14, 4'd6,  4'b1000, 1'b0, 1});
        tbl.push_back('{5'b00011, 1'b1, 4'd14, 4'd6,  4'b0000, 1'b0, 1});
        tbl.push_back('{5'b00011, 1'b1, 4'd6,  4'd14, 4'b1111, 1'b0, 1});
        tbl.push_back('{5'b00100, 1'b1, 4'd14, 4'd6,  4'b0101, 1'b0, 5});
        tbl.push_back('{5'b01000, 1'b1, 4'hC,  4'hA,  4'b1000, 1'b0, 1});
        tbl.push_back('{5'b01100, 1'b0, 4'hC,  4'hA,  4'b1110, 1'b0, 1});
        tbl.push_back('{5'b00000, 1'b0, 4'h9,  4'h0,  4'b0010, 1'b0, 1});
        tbl.push_back('{5'b10000, 1'b1, 4'h9,  4'h0,  4'b0100, 1'b0, 1});
        tbl.push_back('{5'b00001, 1'b0, 4'hF,  4'hF,  4'b0000, 1'b0, 1});
        tbl.push_back('{5'b11111, 1'b1, 4'hF,  4'hF,  4'b0000, 1'b0, 1});
`ifdef ALU_SEQ_DIV_EN
        tbl.push_back('{5'b00110, 1'b0, 4'd14, 4'd6,  4'b0010, 1'b0, 5});
        tbl.push_back('{5'b00110, 1'b1, 4'd14, 4'd6,  4'b0010, 1'b0, 5});
        tbl.push_back('{5'b00110, 1'b0, 4'd9,  4'd0,  4'b1111, 1'b1, 1});
        tbl.push_back('{5'b00110, 1'b1, 4'd9,  4'd0,  4'b1001, 1'b1, 1});
        tbl.push_back('{5'b00010, 1'b0, 4'd1,  4'd2,  4'b0011, 1'b0, 1});
`else
        tbl.push_back('{5'b00110, 1'b0, 4'd14, 4'd6,  4'b0000, 1'b0, 1});
        tbl.push_back('{5'b00110, 1'b0, 4'd9,  4'd0,  4'b0000, 1'b0, 1});
`endif
        foreach (tbl[i]) begin
            apply4($sformatf("tbl%0d_f%b", i, tbl[i].f), tbl[i].f, tbl[i].v, tbl[i].a,
                   tbl[i].b, tbl[i].y, tbl[i].dz, tbl[i].lat);
        end

        // mul with stray starts during MUL and during DONE: both must be ignored
        inject = 1'b1;
        apply4("mul_inject", 5'b00100, 1'b0, 4'd14, 4'd6, 4'b0100, 1'b0, 5);
        inject = 1'b0;

        // CLR on the second iteration aborts without a done pulse
        bus4.start = 1'b1; bus4.f = 5'b00100; bus4.v = 1'b1; bus4.a = 4'd15; bus4.b = 4'd15;
        @(posedge CLK); #1;
        bus4.start = 1'b0;
        @(posedge CLK); #1;
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        chk("abort_state", {bus4.y, bus4.busy, bus4.done}, '0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (bus4.done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        apply4("and_after_abort", 5'b01000, 1'b0, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            f  = ($urandom_range(0, 8) == 8) ? 5'($urandom) : ops[$urandom_range(0, 7)];
            v  = 1'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            model(W, f, v, ra, rb, my, mdz, mlat);
            apply4($sformatf("rnd4_%0d_f%b", i, f), f, v, ra, rb, W'(my), mdz, mlat);
        end

        apply8("mul8_lo", 5'b00100, 1'b0, 8'd200, 8'd100, 8'h20, 1'b0, 9);
        apply8("mul8_hi", 5'b00100, 1'b1, 8'd200, 8'd100, 8'h4E, 1'b0, 9);
        apply8("shl8",    5'b00000, 1'b0, 8'h81,  8'h00,  8'h02, 1'b0, 1);
        apply8("shr8",    5'b10000, 1'b0, 8'h81,  8'h00,  8'h40, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            f   = ops[$urandom_range(0, 7)];
            v   = 1'($urandom);
            ra8 = 8'($urandom);
            rb8 = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            model(8, f, v, ra8, rb8, my, mdz, mlat);
            apply8($sformatf("rnd8_%0d_f%b", i, f), f, v, ra8, rb8, 8'(my), mdz, mlat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
